pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Parametrised lock supervisor and reset sequencer for one or more rPLL instances. It runs on the free-running crystal clock, not on a PLL output. It pulses PLL resets, qualifies lock, and releases downstream domain resets in order. It retries on lock timeout, tears down on lock loss, and reports ready/fail status to the top level.

Parameters:
NUM_PLL, 2, number of supervised PLLs (1..4)
NUM_DOMAINS, 3, number of sequenced domain resets (1..8)
RESET_PULSE, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_FILTER, 1024, consecutive cycles all locks must be high before release (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>=2)
RELEASE_GAP, 64, cycles between successive domain reset releases (>=1)
MAX_RETRY, 3, retries after the first attempt before FAIL (0..15)

Ports:
clk  input  1  free-running reference clock (crystal)
reset_n  input  1  asynchronous active-low reset
pll_lock  input  NUM_PLL  raw lock outputs of the PLLs, asynchronous to clk
retry_req  input  1  single-cycle request; leaves FAIL, ignored in other states
pll_reset  output  NUM_PLL  active-high reset to all PLLs (common value on all bits)
domain_reset_n  output  NUM_DOMAINS  active-low domain resets; bit 0 released first
ready  output  1  high only in RUN
fail  output  1  high only in FAIL
retry_count  output  4  retries consumed in the current bring-up
lost_count  output  8  saturating count of lock-loss events since reset_n

Behaviour:
- Reset (reset_n low, async): state=PLL_RST, counter=0, pll_reset=all 1, domain_reset_n=all 0, ready=0, fail=0, retry_count=0, lost_count=0.
- pll_lock goes through a 2-flop synchroniser per bit. lock_ok = AND of the synced bits. Every "lock" below means lock_ok.
- PLL_RST: pll_reset=1 for exactly RESET_PULSE cycles, then go to WAIT_LOCK with counter cleared. pll_reset=0 in every other state except reset.
- WAIT_LOCK:
  - counter increments each cycle.
  - lock_ok=1 goes to FILTER with counter cleared; this takes priority over timeout in the same cycle.
  - counter==LOCK_TIMEOUT-1 with no lock: if retry_count==MAX_RETRY, go to FAIL; else increment retry_count and go to PLL_RST.
- FILTER:
  - lock_ok must stay 1 for LOCK_FILTER consecutive cycles, then go to RELEASE with index 0.
  - any lock_ok=0 returns to WAIT_LOCK with counter cleared; the timeout restarts and retry_count is unchanged.
- RELEASE:
  - domain_reset_n[0] deasserts on the first RELEASE cycle.
  - domain_reset_n[i] deasserts RELEASE_GAP cycles after bit i-1.
  - one cycle after the last bit is released, go to RUN.
  - released bits stay high.
- RUN: ready=1.
- Lock loss: lock_ok=0 in RELEASE or RUN drives domain_reset_n to all 0 and ready to 0 on the next edge. lost_count increments (saturating at 255), retry_count clears, and the state goes to PLL_RST. Latency from a pll_lock falling edge to domain_reset_n low is at most 3 clk edges.
- FAIL: fail=1, pll_reset=0, domain_reset_n all 0. retry_req=1 goes to PLL_RST with retry_count=0 and fail=0 on the next edge. Only reset_n or retry_req leaves FAIL.
- Counter width is $clog2 of the largest of RESET_PULSE, LOCK_FILTER, LOCK_TIMEOUT, RELEASE_GAP, plus 1. Counters never wrap, because every terminal compare forces a state change.
- All outputs are registered. domain_reset_n is in the clk domain; each consumer must pass it through its own reset synchroniser (async assert, sync deassert).
- reset_n asserted mid-sequence immediately restores the reset values, including re-asserting any released domain_reset_n bits.

Decomposition:
- Shared package pll_pkg holds:
  - the state enum {PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN, FAIL};
  - the counter-width function;
  - constant SYNC_STAGES=2.
- One sub-module, lock_sync: a parametrised NUM_PLL-wide 2-flop synchroniser with async active-low clear to 0. It is reused by other clock-crossing code.

Test Plan:
Bench settings for all scenarios: NUM_PLL=2, NUM_DOMAINS=3, RESET_PULSE=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, RELEASE_GAP=2, MAX_RETRY=2.
- Normal bring-up: release reset_n, raise both locks at cycle 10 -> pll_reset high exactly 4 cycles; domain_reset_n goes 000->001->011->111 at 2-cycle spacing after the 8-cycle filter; ready=1 one cycle after 111; retry_count=0.
- Filter glitch: drop lock[1] for 1 cycle during FILTER cycle 5 -> no release; the filter restarts, and domains release 8 clean cycles after the glitch ends.
- Timeout/fail: hold locks low -> 3 pll_reset pulses (initial + 2 retries), retry_count=2, then fail=1 and domain_reset_n=000; pll_reset stays 0.
- Recovery: in FAIL pulse retry_req, raise locks -> fail=0 next edge, a new 4-cycle pll_reset pulse, normal sequence completes with ready=1.
- Lock loss in RUN: drop lock[0] -> domain_reset_n=000 and ready=0 within 3 edges, lost_count=1, then automatic re-bring-up to ready=1.
- Async reset mid-RELEASE with domain_reset_n=011: pulse reset_n low for half a cycle -> all outputs at reset values immediately, lost_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor and its clock-crossing helpers.
package pll_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    FAIL
  } pll_state_e;

  // One spare bit above the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and status signals of the lock supervisor; slave is the supervisor side.
interface pll_lock_supervisor_if #(
  parameter int NUM_PLL     = 2,
  parameter int NUM_DOMAINS = 3
);
  logic [NUM_PLL-1:0]     pll_lock;
  logic                   retry_req;
  logic [NUM_PLL-1:0]     pll_reset;
  logic [NUM_DOMAINS-1:0] domain_reset_n;
  logic                   ready;
  logic                   fail;
  logic [3:0]             retry_count;
  logic [7:0]             lost_count;

  modport master (
    output pll_lock, retry_req,
    input  pll_reset, domain_reset_n, ready, fail, retry_count, lost_count
  );

  modport slave (
    input  pll_lock, retry_req,
    output pll_reset, domain_reset_n, ready, fail, retry_count, lost_count
  );
endinterface

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Multi-bit flop synchroniser for quasi-static level signals; clears to 0 on reset.
module lock_sync
  import pll_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Lock supervisor / reset sequencer for a set of PLLs, clocked by the crystal reference.
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int NUM_PLL      = 2,
  parameter int NUM_DOMAINS  = 3,
  parameter int RESET_PULSE  = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RELEASE_GAP  = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_lock_supervisor_if.slave  bus
);

  localparam int CW = cnt_width(RESET_PULSE, LOCK_FILTER, LOCK_TIMEOUT, RELEASE_GAP);

  pll_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [3:0]             retry_q, retry_d;
  logic [7:0]             lost_q, lost_d;
  logic [NUM_PLL-1:0]     pll_reset_q;
  logic                   ready_q, fail_q;
  logic [NUM_PLL-1:0]     lock_s;
  logic                   lock_ok;

  lock_sync #(.WIDTH(NUM_PLL)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  assign lock_ok = &lock_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == CW'(RESET_PULSE - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = FILTER;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == 4'(MAX_RETRY)) begin
            state_d = FAIL;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILTER: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          dom_d   = NUM_DOMAINS'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // dom_q is a thermometer: the top bit set means every domain is out of reset.
      RELEASE, RUN: begin
        if (!lock_ok) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          dom_d   = '0;
          retry_d = '0;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (state_q == RELEASE) begin
          if (dom_q[NUM_DOMAINS-1]) begin
            state_d = RUN;
          end else if (cnt_q == CW'(RELEASE_GAP - 1)) begin
            dom_d = NUM_DOMAINS'({dom_q, 1'b1});
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FAIL: begin
        if (bus.retry_req) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      dom_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      pll_reset_q <= '1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dom_q       <= dom_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= {NUM_PLL{state_d == PLL_RST}};
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign bus.pll_reset      = pll_reset_q;
  assign bus.domain_reset_n = dom_q;
  assign bus.ready          = ready_q;
  assign bus.fail           = fail_q;
  assign bus.retry_count    = retry_q;
  assign bus.lost_count     = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed/randomised bench for pll_lock_supervisor; expectations are closed-form timelines.
module tb_pll_lock_supervisor;

  localparam int NP = 2, ND = 3, RP = 4, LF = 8, LT = 32, RG = 2, MR = 2;

  logic clk, reset_n;
  int   n_pass, n_total, cur_e;

  pll_lock_supervisor_if #(.NUM_PLL(NP), .NUM_DOMAINS(ND)) bus ();

  pll_lock_supervisor #(
    .NUM_PLL(NP), .NUM_DOMAINS(ND), .RESET_PULSE(RP), .LOCK_FILTER(LF),
    .LOCK_TIMEOUT(LT), .RELEASE_GAP(RG), .MAX_RETRY(MR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s e=%0d: observed %0h expected %0h", tag, cur_e, obs, exp);
  endtask

  // Released domains at sample e, given the edge r on which bit 0 came out of reset.
  function automatic logic [ND-1:0] dom_exp(input int e, input int r);
    int n;
    if (e < r) return '0;
    n = (e - r) / RG + 1;
    if (n > ND) n = ND;
    return ND'((1 << n) - 1);
  endfunction

  // Caller sits on sample 0, the edge that put the DUT into PLL_RST with a clear counter.
  // Locks are raised so that edge lock_edge samples them; optional 1-cycle glitch on lock[1]
  // seen at edge f+glitch_k; lock_ok lags the raw pins by two edges.
  task automatic bringup_check(input int lock_edge, input int glitch_k, input int last_e);
    int f, g, r, stop;
    f = (lock_edge + 2 > RP + 1) ? lock_edge + 2 : RP + 1;
    g = f + glitch_k;
    if (glitch_k >= 0) f = g + 3;
    r = f + LF;
    stop = (last_e >= 0) ? last_e : r + (ND - 1) * RG + 3;
    for (int e = 0; e <= stop; e++) begin
      if (e > 0) tick();
      cur_e = e;
      chk("pll_reset", bus.pll_reset, (e < RP) ? 32'h3 : 32'h0);
      chk("domain_reset_n", bus.domain_reset_n, dom_exp(e, r));
      chk("ready", bus.ready, (e >= r + (ND - 1) * RG + 1) ? 32'h1 : 32'h0);
      chk("fail", bus.fail, 0);
      chk("retry_count", bus.retry_count, 0);
      if (e == lock_edge - 1) bus.pll_lock = '1;
      if (glitch_k >= 0 && e == g - 1) bus.pll_lock[1] = 1'b0;
      if (glitch_k >= 0 && e == g) bus.pll_lock[1] = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int period, fail_e, stop, pulses, dwell, s;
    logic prev_rst;
    n_pass = 0; n_total = 0; cur_e = 0;
    reset_n = 1'b0;
    bus.pll_lock = '0;
    bus.retry_req = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst pll_reset", bus.pll_reset, 32'h3);
    chk("rst domain_reset_n", bus.domain_reset_n, 0);
    chk("rst ready", bus.ready, 0);
    chk("rst fail", bus.fail, 0);
    chk("rst retry_count", bus.retry_count, 0);
    chk("rst lost_count", bus.lost_count, 0);

    // Normal bring-up, lock rise around cycle 10
    reset_n = 1'b1;
    bringup_check($urandom_range(14, 6), -1, -1);

    // Filter glitch at a random FILTER cycle
    bus.pll_lock = '0;
    apply_reset();
    bringup_check($urandom_range(12, 3), $urandom_range(5, 0), -1);

    // Timeout -> retries -> FAIL; a stray retry_req in WAIT_LOCK is ignored
    bus.pll_lock = '0;
    apply_reset();
    period = RP + LT;
    fail_e = (MR + 1) * period;
    dwell  = $urandom_range(10, 3);
    stop   = fail_e + dwell;
    pulses = 0;
    prev_rst = 1'b0;
    for (int e = 0; e <= stop; e++) begin
      if (e > 0) tick();
      cur_e = e;
      bus.retry_req = (e == 9);
      chk("to pll_reset", bus.pll_reset, (e < fail_e && (e % period) < RP) ? 32'h3 : 32'h0);
      chk("to retry_count", bus.retry_count, (e < fail_e) ? e / period : MR);
      chk("to fail", bus.fail, (e >= fail_e) ? 32'h1 : 32'h0);
      chk("to domain_reset_n", bus.domain_reset_n, 0);
      chk("to ready", bus.ready, 0);
      if (bus.pll_reset[0] && !prev_rst) pulses++;
      prev_rst = bus.pll_reset[0];
    end
    chk("to pulse count", pulses, MR + 1);

    // Recovery from FAIL with locks already present
    bus.retry_req = 1'b1;
    bus.pll_lock  = '1;
    tick();
    bus.retry_req = 1'b0;
    bringup_check(0, -1, -1);
    chk("rec lost_count", bus.lost_count, 0);

    // Lock loss in RUN, then automatic re-bring-up
    dwell = $urandom_range(6, 1);
    for (int i = 0; i < dwell; i++) tick();
    chk("run ready", bus.ready, 1);
    bus.pll_lock[0] = 1'b0;
    tick();
    chk("loss e1 ready", bus.ready, 1);
    tick();
    chk("loss e2 domain_reset_n", bus.domain_reset_n, 32'h7);
    tick();
    chk("loss e3 domain_reset_n", bus.domain_reset_n, 0);
    chk("loss e3 ready", bus.ready, 0);
    chk("loss lost_count", bus.lost_count, 1);
    bus.pll_lock[0] = 1'b0;
    bringup_check($urandom_range(12, 1), -1, -1);
    chk("relock lost_count", bus.lost_count, 1);

    // Second loss, stop mid-RELEASE at 011, then a short async reset
    bus.pll_lock[0] = 1'b0;
    tick(); tick(); tick();
    chk("loss2 lost_count", bus.lost_count, 2);
    s = $urandom_range(6, 1);
    bringup_check(s, -1, ((s + 2 > RP + 1) ? s + 2 : RP + 1) + LF + RG);
    chk("mid domain_reset_n", bus.domain_reset_n, 32'h3);
    #3 reset_n = 1'b0;
    #1;
    chk("async pll_reset", bus.pll_reset, 32'h3);
    chk("async domain_reset_n", bus.domain_reset_n, 0);
    chk("async ready", bus.ready, 0);
    chk("async fail", bus.fail, 0);
    chk("async retry_count", bus.retry_count, 0);
    chk("async lost_count", bus.lost_count, 0);
    #4 reset_n = 1'b1;
    tick();
    chk("post pll_reset", bus.pll_reset, 32'h3);
    chk("post domain_reset_n", bus.domain_reset_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
